// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder that emulates a 12-bit two-channel ADC (start bit, sgl/odd/msbf, null bit, data).
// Optional ADC_LSBF_TAIL_EN macro adds the LSB-first tail after B0 when msbf=0.
//
// state      | meaning
// IDLE       | cs high, outputs quiet
// WAIT_START | cs low, waiting for the first mosi=1 on a rising sck
// CONFIG     | shifting in sgl, odd, msbf
// NULL_BIT   | next falling edge drives the null bit
// DATA       | B11..B0 driven MSB first on falling edges
// TAIL       | B1..B11 driven LSB first (macro builds only)
// HOLD       | frame payload done, miso held at 0 until cs rises
module spi_adc_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    input  logic [11:0] sample_ch0,
    input  logic [11:0] sample_ch1,
    output logic        miso,
    output logic        miso_oe,
    output logic        sample_ack,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  cfg
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CONFIG,
        NULL_BIT,
        DATA,
        TAIL,
        HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic cs_prev_q, cs_prev_d;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  cfg_sh_q, cfg_sh_d;
    logic [2:0]  cfg_q, cfg_d;
    logic [11:0] hold_q, hold_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic        sample_ack_q, sample_ack_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cfg_sh_d     = cfg_sh_q;
        cfg_d        = cfg_q;
        hold_d       = hold_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        sample_ack_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        // cs rise wins over any coincident sck edge
        if (state_q != IDLE && cs_rise) begin
            state_d   = IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            bit_cnt_d = 4'd0;
            case (state_q)
                CONFIG, NULL_BIT, DATA: frame_err_d  = 1'b1;
                TAIL, HOLD:             frame_done_d = 1'b1;
                default:                ;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = WAIT_START;
                        miso_oe_d = 1'b1;
                        miso_d    = 1'b0;
                    end
                end
                WAIT_START: begin
                    if (sck_rise && mosi_s) begin
                        state_d   = CONFIG;
                        bit_cnt_d = 4'd0;
                    end
                end
                CONFIG: begin
                    if (sck_rise) begin
                        if (bit_cnt_q == 4'd2) begin
                            cfg_d        = {cfg_sh_q, mosi_s};
                            hold_d       = cfg_sh_q[0] ? sample_ch1 : sample_ch0;
                            sample_ack_d = 1'b1;
                            state_d      = NULL_BIT;
                            bit_cnt_d    = 4'd0;
                        end else begin
                            cfg_sh_d  = {cfg_sh_q[0], mosi_s};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                NULL_BIT: begin
                    if (sck_fall) begin
                        miso_d    = 1'b0;
                        state_d   = DATA;
                        bit_cnt_d = 4'd11;
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        miso_d = hold_q[bit_cnt_q];
                        if (bit_cnt_q == 4'd0) begin
`ifdef ADC_LSBF_TAIL_EN
                            if (!cfg_q[0]) begin
                                state_d   = TAIL;
                                bit_cnt_d = 4'd1;
                            end else begin
                                state_d   = HOLD;
                                bit_cnt_d = 4'd0;
                            end
`else
                            state_d   = HOLD;
                            bit_cnt_d = 4'd0;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end
`ifdef ADC_LSBF_TAIL_EN
                TAIL: begin
                    if (sck_fall) begin
                        miso_d = hold_q[bit_cnt_q];
                        if (bit_cnt_q == 4'd11) begin
                            state_d   = HOLD;
                            bit_cnt_d = 4'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
`endif
                HOLD: begin
                    // last payload bit stays valid until the following falling edge
                    if (sck_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            cfg_sh_q     <= 2'b00;
            cfg_q        <= 3'b000;
            hold_q       <= 12'h000;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            sample_ack_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cfg_sh_q     <= cfg_sh_d;
            cfg_q        <= cfg_d;
            hold_q       <= hold_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            sample_ack_q <= sample_ack_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign sample_ack = sample_ack_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign cfg        = cfg_q;

endmodule
